gpio_edge_counter: RTL and testbench

- Input-conditioning and event-counting stage for the GPIO input path.
- Samples the 40-pin header inputs, synchronizes and debounces every bit, and counts edges on one selected bit in a 4-digit BCD counter.
- Its debounced levels and BCD digits feed the top-level seven-segment decoders that drive HEX0–HEX3.

---
 rtl/gpio_edge_counter.sv | 140 ++++++++++++++
 tb/tb_gpio_edge_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_edge_counter.sv
// GPIO input conditioning: 2-FF sync, tick-based debounce, and 4-digit BCD edge counter on one selected bit.
// Optional build macro GPIO_BOTH_EDGES_EN: count falling edges as well as rising edges.
module gpio_edge_counter #(
  parameter int WIDTH          = 32,
  parameter int SAMPLE_DIV     = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] GPIO_IN,
  input  logic [4:0]       sel,
  input  logic             clear,
  output logic [WIDTH-1:0] gpio_db,
  output logic             edge_pulse,
  output logic [15:0]      bcd,
  output logic             overflow
);

  localparam int PW = $clog2(SAMPLE_DIV);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] db_q, db_d;
  logic [3:0]       stable_q [WIDTH];
  logic [3:0]       stable_d [WIDTH];
  logic [4:0]       sel_q, sel_prev_q;
  logic             prev_bit_q;
  logic             cur_bit;
  logic             edge_det;
  logic             pulse_q;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q;
  logic             wrap;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= GPIO_IN;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
    end
  end

  assign tick    = (presc_q == PW'(SAMPLE_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // A bit only follows sync after DEBOUNCE_TICKS consecutive disagreeing ticks.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    logic differ;
    logic expired;
    assign differ  = (sync2_q[gi] != db_q[gi]);
    assign expired = (stable_q[gi] == 4'(DEBOUNCE_TICKS - 1));
    assign db_d[gi] = (tick && differ && expired) ? sync2_q[gi] : db_q[gi];
    assign stable_d[gi] = !tick                 ? stable_q[gi] :
                          (!differ || expired)  ? 4'd0         :
                                                  stable_q[gi] + 4'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      db_q     <= '0;
      stable_q <= '{default: 4'd0};
    end else begin
      db_q     <= db_d;
      stable_q <= stable_d;
    end
  end

  // Out-of-range selects leave cur_bit at 0, so nothing is ever counted.
  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_q == 5'(i)) cur_bit = db_q[i];
    end
  end

  always_comb begin
    edge_det = 1'b0;
    if (sel_q == sel_prev_q) begin
`ifdef GPIO_BOTH_EDGES_EN
      edge_det = (cur_bit != prev_bit_q);
`else
      edge_det = cur_bit && !prev_bit_q;
`endif
    end
  end

  always_comb begin
    logic carry;
    bcd_d = bcd_q;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (bcd_q[d*4 +: 4] == 4'd9) begin
          bcd_d[d*4 +: 4] = 4'd0;
        end else begin
          bcd_d[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap = carry;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sel_q      <= '0;
      sel_prev_q <= '0;
      prev_bit_q <= 1'b0;
      pulse_q    <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sel_q      <= sel;
      sel_prev_q <= sel_q;
      prev_bit_q <= cur_bit;
      if (clear) begin
        pulse_q <= 1'b0;
        bcd_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        pulse_q <= edge_det;
        if (edge_det) begin
          bcd_q <= bcd_d;
          if (wrap) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign gpio_db    = db_q;
  assign edge_pulse = pulse_q;
  assign bcd        = bcd_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_gpio_edge_counter.sv
// Randomized bench for gpio_edge_counter against a behavioural model (SAMPLE_DIV=4, DEBOUNCE_TICKS=3).
module tb_gpio_edge_counter;
  localparam int W  = 32;
  localparam int SD = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio;
  logic [4:0]  sel;
  logic        clr;
  logic [31:0] gpio_db;
  logic        edge_pulse;
  logic [15:0] bcd;
  logic        overflow;

  always #5 clk = ~clk;

  gpio_edge_counter #(.WIDTH(W), .SAMPLE_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .GPIO_IN   (gpio),
    .sel       (sel),
    .clear     (clr),
    .gpio_db   (gpio_db),
    .edge_pulse(edge_pulse),
    .bcd       (bcd),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  // Behavioural model state
  bit [31:0] h1, h2;
  int        m_phase;
  int        m_run [W];
  bit [31:0] m_db;
  int        m_selq, m_selqq;
  bit        m_prev;
  int        m_count;
  bit        m_ovf, m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic bit m_edge_now();
    bit cur;
    cur = m_db[m_selq];
    if (m_selq != m_selqq) return 1'b0;
`ifdef GPIO_BOTH_EDGES_EN
    return cur != m_prev;
`else
    return cur && !m_prev;
`endif
  endfunction

  task automatic cycle();
    bit [31:0] g, sync;
    bit c, r, e, cur, tk;
    int s;
    g = gpio; c = clr; r = rst; s = int'(sel);
    @(posedge clk);
    if (r) begin
      h1 = '0; h2 = '0; m_phase = 0; m_db = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_selq = 0; m_selqq = 0; m_prev = 0;
      m_count = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      e   = m_edge_now();
      cur = m_db[m_selq];
      tk  = (m_phase == SD - 1);
      m_phase = (m_phase + 1) % SD;
      sync = h2;
      if (tk) begin
        for (int i = 0; i < W; i++) begin
          if (sync[i] == m_db[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == DT) begin
              m_db[i] = sync[i];
              m_run[i] = 0;
            end
          end
        end
      end
      h2 = h1; h1 = g;
      m_prev = cur; m_selqq = m_selq; m_selq = s;
      if (c) begin
        m_count = 0; m_ovf = 0; m_pulse = 0;
      end else begin
        m_pulse = e;
        if (e) begin
          m_count++;
          if (m_count == 10000) begin m_count = 0; m_ovf = 1; end
        end
      end
    end
    #1;
    check("gpio_db", gpio_db, m_db);
    check("bcd", 32'(bcd), 32'(to_bcd(m_count)));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("edge_pulse", 32'(edge_pulse), 32'(m_pulse));
    if (edge_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int exp_clean;
  int p0;
  bit found;

  initial begin
    gpio = '0; sel = 5'd5; clr = 1'b0; rst = 1'b1;

    // Reset with all inputs high, then settle
    gpio = 32'hFFFF_FFFF;
    run(3);
    rst = 1'b0;
    run(14);
    check("reset_settle", gpio_db, 32'hFFFF_FFFF);
    $display("reset: gpio_db=%h bcd=%h ovf=%0b", gpio_db, bcd, overflow);

    // Glitch rejection
    rst = 1'b1; gpio = '0; run(2); rst = 1'b0; run(20);
    p0 = pulse_cnt;
    gpio[5] = 1'b1; run(3); gpio[5] = 1'b0; run(30);
    for (int k = 0; k < 6; k++) begin
      gpio[$urandom_range(0, 31)] = 1'b1;
      run($urandom_range(1, 3));
      gpio = '0;
      run($urandom_range(4, 12));
    end
    check("glitch_db", gpio_db, 32'h0);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'h0);
    check("glitch_bcd", 32'(bcd), 32'h0);
    $display("glitch: bcd=%h pulses=%0d", bcd, pulse_cnt - p0);

    // Three clean pulses on bit 5
    p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      gpio[5] = 1'b1; run(40);
      gpio[5] = 1'b0; run(40);
    end
`ifdef GPIO_BOTH_EDGES_EN
    exp_clean = 6;
`else
    exp_clean = 3;
`endif
    check("clean_pulses", 32'(pulse_cnt - p0), 32'(exp_clean));
    check("clean_bcd", 32'(bcd), 32'(exp_clean));
    $display("clean: bcd=%h pulses=%0d", bcd, pulse_cnt - p0);

    // Randomized traffic with occasional select changes and clears
    for (int seg = 0; seg < 400; seg++) begin
      gpio = gpio ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 1) == 1) gpio[sel] = ~gpio[sel];
      if ($urandom_range(0, 9) == 0) sel = 5'($urandom_range(0, 31));
      clr = ($urandom_range(0, 24) == 0);
      cycle();
      clr = 1'b0;
      run($urandom_range(0, 29));
    end
    $display("random: bcd=%h ovf=%0b checks=%0d", bcd, overflow, n_checks);

    // Select change onto an already-high bit
    rst = 1'b1; gpio = 32'h0000_0004; sel = 5'd5; run(2); rst = 1'b0; run(20);
    p0 = pulse_cnt;
    sel = 5'd2; run(6);
    check("selchg_pulses", 32'(pulse_cnt - p0), 32'h0);
    check("selchg_bcd", 32'(bcd), 32'h0);
    $display("select change: bcd=%h pulses=%0d", bcd, pulse_cnt - p0);

    // Wrap 9999 -> 0000
    gpio[2] = 1'b0; run(20);
    force dut.bcd_q = 16'h9999;
    #1 release dut.bcd_q;
    m_count = 9999;
    run(2);
    check("preload_bcd", 32'(bcd), 32'h9999);
    gpio[2] = 1'b1; run(20);
    check("wrap_bcd", 32'(bcd), 32'h0);
    check("wrap_ovf", 32'(overflow), 32'h1);
    clr = 1'b1; cycle(); clr = 1'b0; run(1);
    check("clear_ovf", 32'(overflow), 32'h0);
    $display("wrap: bcd=%h ovf=%0b", bcd, overflow);

    // Clear colliding with a counted edge
    gpio[2] = 1'b0; run(20);
    gpio[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_edge_now()) begin
        found = 1'b1;
        clr = 1'b1; cycle(); clr = 1'b0;
        check("collide_pulse", 32'(edge_pulse), 32'h0);
        check("collide_bcd", 32'(bcd), 32'h0);
      end else begin
        cycle();
      end
    end
    check("collide_found", 32'(found), 32'h1);
    run(5);
    $display("clear collision: bcd=%h pulse=%0b", bcd, edge_pulse);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
